// File: rtl/clk_div_pkg.sv
// Shared constants, divide-ratio type and period helper for the clk_div_gen slice.
package clk_div_pkg;

  localparam int NCH     = 2;
  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 0;

  typedef logic [CNT_W-1:0] div_t;

  // Full output period in sys_clk cycles for a given divide value.
  function automatic int period_of(input div_t div);
    return 2 * (int'(div) + 1);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow ratio, divided clock and edge strobes.
module clk_div_chan #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 0
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             ch_en,
  input  logic             cfg_load,
  input  logic             sync_restart,
  input  logic [CNT_W-1:0] div_in,
  output logic             clk_out,
  output logic             ce_rise,
  output logic             ce_fall,
  output logic             pending
);
  import clk_div_pkg::*;

  localparam logic [CNT_W-1:0] DEF_VAL = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] active_div_reg, active_div_next;
  logic [CNT_W-1:0] shadow_reg, shadow_next;
  logic             pending_reg, pending_next;
  logic             clk_reg, clk_next;
  logic             rise_reg, rise_next;
  logic             fall_reg, fall_next;
  logic             tc;

  assign tc = (cnt_reg == active_div_reg);

  always_comb begin
    cnt_next        = cnt_reg;
    active_div_next = active_div_reg;
    shadow_next     = shadow_reg;
    pending_next    = pending_reg;
    clk_next        = clk_reg;
    rise_next       = 1'b0;
    fall_next       = 1'b0;

    if (sync_restart) begin
      cnt_next = '0;
      clk_next = 1'b0;
      if (cfg_load) begin
        active_div_next = div_in;
        shadow_next     = div_in;
        pending_next    = 1'b0;
      end else if (pending_reg) begin
        active_div_next = shadow_reg;
        pending_next    = 1'b0;
      end
    end else begin
      if (!ch_en) begin
        // A forced stop is not a clock edge, so no strobe accompanies it.
        cnt_next = '0;
        clk_next = 1'b0;
      end else if (tc) begin
        cnt_next  = '0;
        clk_next  = ~clk_reg;
        rise_next = ~clk_reg;
        fall_next = clk_reg;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end

      // A load coinciding with TC must wait for the following TC.
      if (cfg_load) begin
        shadow_next  = div_in;
        pending_next = 1'b1;
      end else if (pending_reg && (!ch_en || tc)) begin
        active_div_next = shadow_reg;
        pending_next    = 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      active_div_reg <= DEF_VAL;
      shadow_reg     <= DEF_VAL;
      pending_reg    <= 1'b0;
      clk_reg        <= 1'b0;
      rise_reg       <= 1'b0;
      fall_reg       <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      active_div_reg <= active_div_next;
      shadow_reg     <= shadow_next;
      pending_reg    <= pending_next;
      clk_reg        <= clk_next;
      rise_reg       <= rise_next;
      fall_reg       <= fall_next;
    end
  end

  assign clk_out = clk_reg;
  assign ce_rise = rise_reg;
  assign ce_fall = fall_reg;
  assign pending = pending_reg;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider with glitch-free ratio updates and common restart.
module clk_div_gen #(
  parameter int NCH     = clk_div_pkg::NCH,
  parameter int CNT_W   = clk_div_pkg::CNT_W,
  parameter int DEF_DIV = clk_div_pkg::DEF_DIV
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       ch_en,
  input  logic [NCH*CNT_W-1:0] div_val,
  input  logic                 cfg_load,
  input  logic                 sync_restart,
  output logic [NCH-1:0]       clk_out,
  output logic [NCH-1:0]       ce_rise,
  output logic [NCH-1:0]       ce_fall,
  output logic                 cfg_busy
);
  import clk_div_pkg::*;

  logic [NCH-1:0] pending_vec;
  logic           busy_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      clk_div_chan #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
      ) u_chan (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .ch_en        (ch_en[gi]),
        .cfg_load     (cfg_load),
        .sync_restart (sync_restart),
        .div_in       (div_val[gi*CNT_W +: CNT_W]),
        .clk_out      (clk_out[gi]),
        .ce_rise      (ce_rise[gi]),
        .ce_fall      (ce_fall[gi]),
        .pending      (pending_vec[gi])
      );
    end
  endgenerate

  // Registered, so busy trails the pending bits by one cycle.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      busy_reg <= 1'b0;
    end else begin
      busy_reg <= |pending_vec;
    end
  end

  assign cfg_busy = busy_reg;

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed self-checking bench for clk_div_gen with default parameters (2 channels, 8-bit ratios).
module tb_clk_div_gen;
  import clk_div_pkg::*;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ch_en = 2'b00;
  logic [15:0] div_val = 16'h0000;
  logic        cfg_load = 1'b0;
  logic        sync_restart = 1'b0;
  logic [1:0]  clk_out;
  logic [1:0]  ce_rise;
  logic [1:0]  ce_fall;
  logic        cfg_busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int overlap = 0;
  int m = 0;
  int r0[$];
  int f0[$];
  int r1[$];
  int f1[$];

  clk_div_gen dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .ch_en        (ch_en),
    .div_val      (div_val),
    .cfg_load     (cfg_load),
    .sync_restart (sync_restart),
    .clk_out      (clk_out),
    .ce_rise      (ce_rise),
    .ce_fall      (ce_fall),
    .cfg_busy     (cfg_busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s = %0d (cycle %0d)", tag, got, cyc);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic clearq();
    r0.delete();
    f0.delete();
    r1.delete();
    f1.delete();
  endtask

  // Record the cycle index of every strobe over n cycles.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (ce_rise[0]) r0.push_back(cyc);
      if (ce_fall[0]) f0.push_back(cyc);
      if (ce_rise[1]) r1.push_back(cyc);
      if (ce_fall[1]) f1.push_back(cyc);
      if ((ce_rise & ce_fall) != 2'b00) overlap++;
    end
  endtask

  function automatic int qat(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1000;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_clk_out", 32'(clk_out), 0);
    chk("rst_ce_rise", 32'(ce_rise), 0);
    chk("rst_ce_fall", 32'(ce_fall), 0);
    chk("rst_busy", 32'(cfg_busy), 0);

    // Default divide: sys_clk/2 on both channels
    rst = 1'b0;
    ch_en = 2'b11;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("div2_clk", 32'(clk_out), (k % 2 == 1) ? 3 : 0);
      chk("div2_rise", 32'(ce_rise), (k % 2 == 1) ? 3 : 0);
      chk("div2_fall", 32'(ce_fall), (k % 2 == 1) ? 0 : 3);
    end
    chk("div2_busy", 32'(cfg_busy), 0);

    // Load ch0=4, ch1=9; load edge is also a TC so old ratio toggles first
    div_val = {8'd9, 8'd4};
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("load_busy_lag", 32'(cfg_busy), 0);
    chk("load_edge_clk", 32'(clk_out), 3);
    tick();
    chk("apply_busy", 32'(cfg_busy), 1);
    chk("apply_clk", 32'(clk_out), 0);
    m = cyc;
    tick();
    chk("apply_busy_drop", 32'(cfg_busy), 0);
    clearq();
    capture(39);
    chk("ch0_first_rise", 32'(qat(r0, 0) - m), 5);
    chk("ch0_period", 32'(qat(r0, 1) - qat(r0, 0)), 32'(period_of(8'd4)));
    chk("ch0_first_fall", 32'(qat(f0, 0) - m), 10);
    chk("ch1_first_rise", 32'(qat(r1, 0) - m), 10);
    chk("ch1_period", 32'(qat(r1, 1) - qat(r1, 0)), 32'(period_of(8'd9)));
    chk("ch1_first_fall", 32'(qat(f1, 0) - m), 20);

    // cfg_load exactly on ch0 TC: toggle uses 4, next TC still 4, then 3
    m = cyc;
    for (int i = 0; i < 4; i++) tick();
    div_val = {8'd9, 8'd2};
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("tc_load_rise", 32'(ce_rise[0]), 1);
    clearq();
    capture(11);
    chk("tc_load_fall", 32'(qat(f0, 0) - m), 10);
    chk("tc_new_half1", 32'(qat(r0, 0) - qat(f0, 0)), 3);
    chk("tc_new_half2", 32'(qat(f0, 1) - qat(r0, 0)), 3);

    // Disable ch0 while high: forced low with no ce_fall
    tick();
    tick();
    tick();
    chk("pre_dis_clk0", 32'(clk_out[0]), 1);
    ch_en = 2'b10;
    tick();
    chk("dis_clk0", 32'(clk_out[0]), 0);
    chk("dis_no_fall", 32'(ce_fall[0]), 0);
    tick();
    tick();
    chk("dis_hold_clk0", 32'(clk_out[0]), 0);
    ch_en = 2'b11;
    m = cyc;
    clearq();
    capture(3);
    chk("reen_rise", 32'(qat(r0, 0) - m), 3);

    // sync_restart with simultaneous load: ch0=2, ch1=5 applied at once
    div_val = {8'd5, 8'd2};
    cfg_load = 1'b1;
    sync_restart = 1'b1;
    tick();
    cfg_load = 1'b0;
    sync_restart = 1'b0;
    chk("restart_clk", 32'(clk_out), 0);
    chk("restart_rise", 32'(ce_rise), 0);
    chk("restart_fall", 32'(ce_fall), 0);
    m = cyc;
    tick();
    chk("restart_busy", 32'(cfg_busy), 0);
    clearq();
    capture(11);
    chk("restart_ch0_rise", 32'(qat(r0, 0) - m), 3);
    chk("restart_ch1_rise", 32'(qat(r1, 0) - m), 6);
    chk("restart_ch0_fall", 32'(qat(f0, 0) - m), 6);

    // Reset mid-period with a pending load
    div_val = {8'd7, 8'd7};
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    tick();
    chk("pend_busy", 32'(cfg_busy), 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_clk", 32'(clk_out), 0);
    chk("mid_rst_rise", 32'(ce_rise), 0);
    chk("mid_rst_fall", 32'(ce_fall), 0);
    chk("mid_rst_busy", 32'(cfg_busy), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_rise", 32'(ce_rise), 3);
    chk("post_rst_clk", 32'(clk_out), 3);
    tick();
    chk("post_rst_fall", 32'(ce_fall), 3);
    chk("post_rst_busy", 32'(cfg_busy), 0);

    chk("strobe_excl", 32'(overlap), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
